pipe_chain: RTL
===============

PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 Parameter DEPTH, default 4, number of pipeline stages (2..8); stage 0 youngest, stage DEPTH-1 oldest.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low; one clock, reset is synchronous and active-low.
REQ-005 Port in_valid  input  1  upstream offers in_data.
REQ-006 Port in_ready  output  1  stage 0 accepts this cycle.
REQ-007 Port in_data  input  WIDTH  upstream payload.
REQ-008 Port out_valid  output  1  stage DEPTH-1 holds a live item.
REQ-009 Port out_ready  input  1  downstream accepts this cycle.
REQ-010 Port out_data  output  WIDTH  payload of stage DEPTH-1.
REQ-011 Port stall  input  1  global freeze (hazard hold).
REQ-012 Port kill  input  DEPTH  per-stage squash; bit i squashes the item in stage i.
REQ-013 Port count  output  $clog2(DEPTH+1)  registered number of valid stages.

Function
REQ-014 Each stage i SHALL hold valid[i] and data[i]; a stage is live when valid[i]=1 and kill[i]=0.
REQ-015 out_valid SHALL equal valid[DEPTH-1] & ~kill[DEPTH-1] & ~stall; out_data SHALL equal data[DEPTH-1].
REQ-016 Stage DEPTH-1 SHALL empty when out_valid & out_ready (transfer) or when kill[DEPTH-1]=1.
REQ-017 Stage i<DEPTH-1 SHALL advance into stage i+1 when live, stall=0, and stage i+1 is empty after this cycle (not valid, killed, or itself advancing).
REQ-018 Bubble collapse: a live item SHALL advance into any empty downstream stage even when upstream stages are empty or blocked.
REQ-019 in_ready SHALL equal ~stall & (stage 0 not valid | kill[0] | stage 0 advancing); the path is combinational from out_ready and kill.
REQ-020 When in_valid & in_ready, stage 0 SHALL capture in_data with valid=1 at the next edge.
REQ-021 A killed item SHALL never advance, never appear on out_valid, and its stage SHALL be free for capture in the same cycle.
REQ-022 kill SHALL take priority over stall; with stall=1 killed stages clear, all other stages hold data and valid.
REQ-023 With stall=0, out_ready=1 and no kill, latency in_data->out_data SHALL be exactly DEPTH cycles, throughput 1 item/cycle.
REQ-024 With out_ready=0 and stall=0, items SHALL compact toward stage DEPTH-1; in_ready falls only when all DEPTH stages are valid and unkilled.
REQ-025 Simultaneous full + transfer out + in_valid SHALL accept the new item (pass-through of back-pressure release).
REQ-026 count SHALL equal the number of valid stages after the edge; range 0..DEPTH, never wraps.
REQ-027 Items SHALL stay in order; no duplication, no loss except via kill.
REQ-028 data[i] of an invalid stage is don't-care internally but SHALL NOT affect any output except out_data when out_valid=0.

Reset
REQ-029 When rst=0 at a rising edge: all valid[i]=0, all data[i]=0, count=0.
REQ-030 During reset cycles out_valid=0, out_data=0, in_ready=0, and in_valid is ignored.
REQ-031 Reset mid-operation SHALL discard all in-flight items; first accept possible on the first edge with rst=1.

Verification
REQ-032 Stream: DEPTH=4, in 0x11,0x22,0x33 on cycles 0-2, out_ready=1 -> out_data 0x11,0x22,0x33 on cycles 4,5,6, count peaks at 3.
REQ-033 Back-pressure: out_ready=0, offer 6 items -> first 4 accepted, in_ready=0 after 4th, count=4; out_ready=1 -> 1 item/cycle out in order, in_ready=1 same cycle.
REQ-034 Kill: items A,B,C in stages 3,2,1, kill=4'b0100 one cycle -> B never output, outputs A then C, count drops by 1.
REQ-035 Stall: full pipe, stall=1 for 3 cycles -> out_valid=0, in_ready=0, contents/count unchanged; with kill[0]=1 during stall stage 0 clears, count=3.
REQ-036 Bubble collapse: single item, out_ready=0 -> reaches stage 3 after 4 cycles and holds; second item settles in stage 2, count=2.
REQ-037 Reset mid-run: count=3, rst=0 one edge -> count=0, out_valid=0; next item after rst=1 emerges DEPTH cycles later.

Source files
------------

// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - elastic pipeline with per-stage kill, global stall and bubble collapse
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       stall,
  input  logic [DEPTH-1:0]           kill,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nxt;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data [DEPTH];
  logic             take;
  logic [CW-1:0]    count_nxt;

  assign out_valid = rst & valid[DEPTH-1] & ~kill[DEPTH-1] & ~stall;
  assign out_data  = rst ? data[DEPTH-1] : '0;

  // Walk oldest to youngest: 'down_free' is whether the stage just downstream
  // will be empty after this edge, which lets a live item fill any bubble.
  always_comb begin
    logic down_free;
    logic step;
    valid_nxt = '0;
    adv       = '0;
    in_ready  = 1'b0;
    take      = 1'b0;
    count_nxt = '0;
    down_free = ~valid[DEPTH-1] | kill[DEPTH-1] | (out_valid & out_ready);
    valid_nxt[DEPTH-1] = valid[DEPTH-1] & ~down_free;
    for (int i = DEPTH-2; i >= 0; i--) begin
      step   = valid[i] & ~kill[i] & ~stall & down_free;
      adv[i] = step;
      if (step) valid_nxt[i+1] = 1'b1;
      down_free    = ~valid[i] | kill[i] | step;
      valid_nxt[i] = valid[i] & ~down_free;
    end
    in_ready = rst & ~stall & down_free;
    take     = in_valid & in_ready;
    if (take) valid_nxt[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      count_nxt = count_nxt + CW'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
    end else begin
      valid <= valid_nxt;
      count <= count_nxt;
      if (take) data[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) data[i] <= data[i-1];
      end
    end
  end

endmodule
